alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Operands are latched on grant; multiplies wait MUL_WAIT extra cycles before capture.
module alu_arbiter #(
  parameter int MUL_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_sel,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_result,
  output logic        rsp_of,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_result,
  input  logic        alu_of
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MUL_WAIT);
  localparam logic [2:0] SEL_ADD  = 3'b010;
  localparam logic [2:0] SEL_MUL  = 3'b100;
  localparam logic [2:0] SEL_SUB  = 3'b110;

  state_t      state;
  state_t      next_state;
  logic        grant;
  logic        pick;
  logic        any_valid;
  logic        accept;
  logic        capture;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_sel;
  logic [3:0]  wait_cnt;

  // grant doubles as the last-grant record; reset to 1 so requester 0 wins first
  assign any_valid = req0_valid | req1_valid;
  assign pick      = (req0_valid & req1_valid) ? ~grant : req1_valid;
  assign accept    = (state == IDLE) & any_valid;
  assign capture   = (state == EXEC) & ((op_sel != SEL_MUL) | (wait_cnt == WAIT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_valid) next_state = EXEC;
      EXEC:    if (capture)   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid & ~pick;
        req1_ready = req1_valid & pick;
      end
      RESP: begin
        rsp0_valid = ~grant;
        rsp1_valid = grant;
      end
      default: ;
    endcase
  end

  assign busy    = (state != IDLE);
  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_sel = op_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      wait_cnt   <= '0;
      rsp_result <= '0;
      rsp_of     <= 1'b0;
    end else begin
      if (accept) begin
        grant  <= pick;
        op_a   <= pick ? req1_a   : req0_a;
        op_b   <= pick ? req1_b   : req0_b;
        op_sel <= pick ? req1_sel : req0_sel;
      end
      // counts only while a multiply is still waiting; zero whenever EXEC is left
      if ((state == EXEC) && !capture) begin
        wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_of     <= ((op_sel == SEL_ADD) || (op_sel == SEL_SUB)) & alu_of;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared-ALU model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp1_valid, rsp_of, busy, alu_of;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_sel;
  logic [63:0] prod;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.MUL_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result), .rsp_of(rsp_of),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_of(alu_of)
  );

  // shared ALU: mul flags a non-zero upper half so the arbiter's masking is observable
  always_comb begin
    alu_result = '0;
    alu_of     = 1'b0;
    prod       = '0;
    case (alu_sel)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: begin
        alu_result = alu_a + alu_b;
        alu_of = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b011: alu_result = alu_a << alu_b[4:0];
      3'b100: begin
        prod = {32'd0, alu_a} * {32'd0, alu_b};
        alu_result = prod[31:0];
        alu_of = |prod[63:32];
      end
      3'b101: alu_result = alu_a >> alu_b[4:0];
      3'b110: begin
        alu_result = alu_a - alu_b;
        alu_of = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      default: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sel);
    if (r) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
    end
  endtask

  // called just after a falling edge; returns just after a falling edge
  task automatic run_op(input logic r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                        input logic [31:0] er, input logic eo, input int elat, input string tag);
    int cyc;
    drive(r, 1'b1, a, b, sel);
    #1;
    cyc = 0;
    while (!(r ? req1_ready : req0_ready) && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    check({tag, "_accept"}, 32'(cyc < 20), 32'd1);
    check({tag, "_other_ready"}, 32'(r ? req0_ready : req1_ready), 32'd0);
    @(negedge clk);
    // scramble inputs after acceptance; the in-flight op must be unaffected
    drive(r, 1'b0, ~a, ~b, ~sel);
    #1;
    cyc = 1;
    while (!(rsp0_valid | rsp1_valid) && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(elat));
    check({tag, "_rsp_own"}, 32'(r ? rsp1_valid : rsp0_valid), 32'd1);
    check({tag, "_rsp_other"}, 32'(r ? rsp0_valid : rsp1_valid), 32'd0);
    check({tag, "_result"}, rsp_result, er);
    check({tag, "_of"}, 32'(rsp_of), 32'(eo));
    @(negedge clk); #1;
    check({tag, "_rsp_oneshot"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, rsp_result, er);
  endtask

  initial begin
    int k;
    int n_rsp;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_of", 32'(rsp_of), 32'd0);
    check("rst_alu_ops", {alu_a[15:0], alu_b[12:0], alu_sel}, 32'd0);
    check("rst_ready_idle", 32'({req0_ready, req1_ready}), 32'd0);

    // both requesters valid straight out of reset: and / or ops, held for 12 grants
    drive(1'b0, 1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b000);
    drive(1'b1, 1'b1, 32'h0000_F000, 32'h0000_0F00, 3'b001);
    #1;
    check("rst_prio_req0", 32'(req0_ready), 32'd1);
    check("rst_prio_req1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    n_rsp = 0;
    for (int c = 0; c < 60; c++) begin
      if (k == 12) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (req0_ready & req1_ready) check("both_ready", 32'd1, 32'd0);
      if (rsp0_valid & rsp1_valid) check("both_rsp", 32'd1, 32'd0);
      if (req0_ready | req1_ready) begin
        check($sformatf("grant_%0d", k), 32'(req1_ready), 32'(k % 2));
        k++;
      end
      if (rsp0_valid) begin
        check($sformatf("rsp0_and_%0d", n_rsp), rsp_result, 32'h0000_0000);
        n_rsp++;
      end
      if (rsp1_valid) begin
        check($sformatf("rsp1_or_%0d", n_rsp), rsp_result, 32'h0000_FF00);
        n_rsp++;
      end
      @(negedge clk);
    end
    check("arb_grants", 32'(k), 32'd12);
    check("arb_responses", 32'(n_rsp), 32'd12);

    run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b1, 2, "add_ovf");
    run_op(1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 3'b100, 32'hFFFF_FFFD, 1'b0, 4, "mul");
    run_op(1'b0, 32'h0000_0001, 32'h0000_0024, 3'b011, 32'h0000_0010, 1'b0, 2, "sll");
    run_op(1'b1, 32'h8000_0000, 32'h0000_001F, 3'b101, 32'h0000_0001, 1'b0, 2, "srl");
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0, 2, "slt");
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 3'b110, 32'h7FFF_FFFF, 1'b1, 2, "sub_ovf");

    // reset during the wait phase of a multiply
    drive(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0005, 3'b100);
    #1;
    k = 0;
    while (!req1_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    check("rstmid_accept", 32'(k < 20), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_result", rsp_result, 32'd0);
    check("rstmid_of", 32'(rsp_of), 32'd0);
    check("rstmid_alu_a", alu_a, 32'd0);
    check("rstmid_alu_sel", 32'(alu_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (rsp0_valid | rsp1_valid | busy) n_rsp++;
    end
    check("rstmid_no_strobe", 32'(n_rsp), 32'd0);
    run_op(1'b0, 32'h0000_0005, 32'h0000_0003, 3'b110, 32'h0000_0002, 1'b0, 2, "sub_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
